stream_capture: RTL and testbench
=================================

STREAM_CAPTURE -- requirements
Module: stream_capture

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload bits per channel (1..64).
REQ-002 Parameter DEPTH, default 16: capture buffer entries; power of two, >=2.
REQ-003 Parameter CHANNELS, default 2: number of valid/ready input channels (1..8).
REQ-004 Parameter WRAP, default 0: 0 = stop when full, 1 = circular overwrite of oldest entry.
REQ-005 Derived widths: AW = log2(DEPTH); CW = max(1, ceil(log2(CHANNELS))).
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 valid  in  CHANNELS  per-channel data-valid.
REQ-009 ready  out  CHANNELS  per-channel accept; at most one bit high per cycle.
REQ-010 data  in  CHANNELS*DATA_WIDTH  channel i payload at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 rd_en  in  1  pop request for the oldest stored entry.
REQ-012 rd_data  out  DATA_WIDTH  popped payload, registered.
REQ-013 rd_chan  out  CW  source channel of popped payload, registered.
REQ-014 rd_valid  out  1  rd_data/rd_chan valid, one-cycle pulse.
REQ-015 count  out  AW+1  stored entries (0..DEPTH).
REQ-016 full, empty  out  1 each  count==DEPTH, count==0; registered.

Function
REQ-017 Transfer on channel i occurs at a rising edge where valid[i] and ready[i] are both high; at most one transfer per cycle.
REQ-018 Round-robin arbiter: grant is the first channel with valid high, searching from rr_ptr upward modulo CHANNELS; ready = one-hot grant, gated low when full and WRAP=0.
REQ-019 ready depends on valid and registered state only; never on rd_en.
REQ-020 After a transfer from channel g, rr_ptr becomes (g+1) mod CHANNELS; otherwise rr_ptr holds.
REQ-021 Transfer writes {g, data_g} to mem[wr_ptr]; wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
REQ-022 rd_en with empty low pops mem[rd_ptr] into rd_data/rd_chan with rd_valid high the next cycle (latency 1); rd_ptr increments modulo DEPTH.
REQ-023 rd_en with empty high is ignored: no pointer change, rd_valid low, rd_data/rd_chan hold.
REQ-024 Simultaneous write and pop (not full): count unchanged; pop returns the entry existing before the write.
REQ-025 Full, WRAP=0: no ready; a same-cycle pop frees a slot, with ready re-enabled the following cycle.
REQ-026 Full, WRAP=1, write without pop: oldest entry overwritten; rd_ptr increments; count stays DEPTH.
REQ-027 Full, WRAP=1, write with pop: pop returns the oldest entry; write lands; count stays DEPTH; no overwrite recorded.
REQ-028 Storage entry width DATA_WIDTH+CW; CHANNELS=1 tags channel 0.

Reset
REQ-029 While rst is low at a rising edge: wr_ptr, rd_ptr, rr_ptr, count = 0; empty = 1; full = 0; rd_valid = 0; rd_data = 0; rd_chan = 0.
REQ-030 ready is all-zero during any cycle in which rst is low; memory contents are not cleared.
REQ-031 Reset asserted mid-operation discards all stored entries and any pending pop; first transfer is accepted in the cycle after rst returns high.

Configuration
REQ-032 Macro STREAM_CAPTURE_OVF_CNT_EN defined: adds output ovf_cnt, 16 bits, reset 0, saturating at 16'hFFFF.
REQ-033 With the macro, WRAP=1: ovf_cnt increments per overwrite (REQ-026); WRAP=0: increments per cycle with any valid high while full.
REQ-034 Macro undefined: ovf_cnt port and its logic absent; all other behaviour identical.

Verification
REQ-035 Reset: rst low 10 cycles with valid=2'b11 -> ready=0, empty=1, count=0, rd_valid=0 throughout.
REQ-036 Single channel: ch0 sends 1..16 (DEPTH=16, WRAP=0) -> full=1 after 16th, ready[0]=0; 17th and 18th held; 16 pops return 1..16, rd_chan=0, each one cycle after rd_en.
REQ-037 Arbitration: both channels valid continuously, ch0 data 8'hA0.., ch1 8'hB0.. -> grants alternate 0,1,0,1; popped rd_chan sequence 0,1,0,1.
REQ-038 Wrap mode (WRAP=1): 18 writes of 1..18, no pops -> count=16, pops return 3..18; ovf_cnt=2 with macro defined.
REQ-039 Boundary: full with rd_en and valid same cycle, WRAP=0 -> pop returns oldest, count=15, ready asserts next cycle; pop on empty -> rd_valid stays 0.
REQ-040 Reset mid-stream after 5 writes -> count=0, empty=1 next cycle; subsequent write of 8'h55 pops as 8'h55.

Source files
------------

// File: rtl/stream_capture.sv
// stream_capture: round-robin capture of several valid/ready channels into one tagged FIFO.
// Define STREAM_CAPTURE_OVF_CNT_EN to add the saturating 16-bit ovf_cnt output.
module stream_capture #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CHANNELS   = 2,
    parameter int WRAP       = 0,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            valid,
    output logic [CHANNELS-1:0]            ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data,
    input  logic                           rd_en,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [CW-1:0]                  rd_chan,
    output logic                           rd_valid,
    output logic [AW:0]                    count,
    output logic                           full,
    output logic                           empty
`ifdef STREAM_CAPTURE_OVF_CNT_EN
    ,
    output logic [15:0]                    ovf_cnt
`endif
);

    localparam int          EW         = DATA_WIDTH + CW;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [EW-1:0]         r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_rr_ptr;

    logic                  w_found;
    logic [CW-1:0]         w_gnt;
    logic [DATA_WIDTH-1:0] w_gnt_data;
    logic                  w_block;
    logic                  w_wr;
    logic                  w_pop;
    logic                  w_overwrite;
    logic [AW:0]           w_count_nxt;
    logic [CW-1:0]         w_rr_nxt;

    // Two passes give a search from r_rr_ptr upward that wraps back to channel 0.
    always_comb begin
        w_found    = 1'b0;
        w_gnt      = '0;
        w_gnt_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && valid[i] && (i >= int'(r_rr_ptr))) begin
                w_found    = 1'b1;
                w_gnt      = CW'(i);
                w_gnt_data = data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && valid[i]) begin
                w_found    = 1'b1;
                w_gnt      = CW'(i);
                w_gnt_data = data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_block = full && (WRAP == 0);

    always_comb begin
        ready = '0;
        if (rst && w_found && !w_block) begin
            ready = CHANNELS'(1) << w_gnt;
        end
    end

    assign w_wr        = |(valid & ready);
    assign w_pop       = rd_en && !empty;
    assign w_overwrite = w_wr && !w_pop && full;
    assign w_rr_nxt    = (w_gnt == CW'(CHANNELS-1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        w_count_nxt = count;
        if (w_wr && !w_pop && !full) begin
            w_count_nxt = count + 1'b1;
        end else if (w_pop && !w_wr) begin
            w_count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {w_gnt, w_gnt_data};
        end
    end

    // A pop reads the pre-write slot contents, so a same-slot write in wrap mode is safe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rr_ptr <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_chan  <= '0;
        end else begin
            rd_valid <= w_pop;
            if (w_pop) begin
                {rd_chan, rd_data} <= r_mem[r_rd_ptr];
            end
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= w_rr_nxt;
            end
            if (w_pop || w_overwrite) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            count <= w_count_nxt;
            full  <= (w_count_nxt == FULL_COUNT);
            empty <= (w_count_nxt == '0);
        end
    end

`ifdef STREAM_CAPTURE_OVF_CNT_EN
    logic w_ovf_evt;

    assign w_ovf_evt = (WRAP != 0) ? w_overwrite : (full && (|valid));

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_cnt <= '0;
        end else if (w_ovf_evt && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_capture.sv
// Directed bench for stream_capture: one stop-when-full instance and one wrap-mode instance.
module tb_stream_capture;

    logic        clk;
    logic        rst;
    logic [1:0]  valid;
    logic [1:0]  ready;
    logic [15:0] data;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic [0:0]  rd_chan;
    logic        rd_valid;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    logic [1:0]  w_valid;
    logic [1:0]  w_ready;
    logic [15:0] w_data;
    logic        w_rd_en;
    logic [7:0]  w_rd_data;
    logic [0:0]  w_rd_chan;
    logic        w_rd_valid;
    logic [4:0]  w_count;
    logic        w_full;
    logic        w_empty;
`ifdef STREAM_CAPTURE_OVF_CNT_EN
    logic [15:0] ovf_cnt;
    logic [15:0] w_ovf_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    stream_capture #(.DATA_WIDTH(8), .DEPTH(16), .CHANNELS(2), .WRAP(0)) u_dut (
        .clk(clk), .rst(rst), .valid(valid), .ready(ready), .data(data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_chan(rd_chan), .rd_valid(rd_valid), .count(count),
        .full(full), .empty(empty)
`ifdef STREAM_CAPTURE_OVF_CNT_EN
        , .ovf_cnt(ovf_cnt)
`endif
    );

    stream_capture #(.DATA_WIDTH(8), .DEPTH(16), .CHANNELS(2), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .valid(w_valid), .ready(w_ready), .data(w_data), .rd_en(w_rd_en),
        .rd_data(w_rd_data), .rd_chan(w_rd_chan), .rd_valid(w_rd_valid), .count(w_count),
        .full(w_full), .empty(w_empty)
`ifdef STREAM_CAPTURE_OVF_CNT_EN
        , .ovf_cnt(w_ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        valid = 2'b11;
        data  = 16'hB1A1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_tests++; if (ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready cyc %0d: got %b want 00", c, ready); end
            n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty cyc %0d: got %b want 1", c, empty); end
            n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count cyc %0d: got %0d want 0", c, count); end
            n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid cyc %0d: got %b want 0", c, rd_valid); end
        end
        n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        rst   = 1'b1;
        valid = 2'b00;
    endtask

    task automatic test_single();
        for (int i = 1; i <= 16; i++) begin
            valid = 2'b01;
            data  = {8'h00, 8'(i)};
            #1;
            n_tests++; if (ready !== 2'b01) begin n_fail++; $display("FAIL single_ready wr %0d: got %b want 01", i, ready); end
            tick();
        end
        data = 16'h0011;
        #1;
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL single_full: got %b want 1", full); end
        n_tests++; if (ready !== 2'b00) begin n_fail++; $display("FAIL single_ready_full17: got %b want 00", ready); end
        tick();
        data = 16'h0012;
        #1;
        n_tests++; if (ready !== 2'b00) begin n_fail++; $display("FAIL single_ready_full18: got %b want 00", ready); end
        tick();
        n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL single_count_held: got %0d want 16", count); end
        valid = 2'b00;
        for (int k = 1; k <= 16; k++) begin
            rd_en = 1'b1;
            tick();
            n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_rd_valid pop %0d: got %b want 1", k, rd_valid); end
            n_tests++; if (rd_data !== 8'(k)) begin n_fail++; $display("FAIL single_rd_data pop %0d: got %h want %h", k, rd_data, 8'(k)); end
            n_tests++; if (rd_chan !== 1'b0) begin n_fail++; $display("FAIL single_rd_chan pop %0d: got %0d want 0", k, rd_chan); end
        end
        rd_en = 1'b0;
        tick();
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_rd_valid_idle: got %b want 0", rd_valid); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b want 1", empty); end
    endtask

    task automatic test_full_boundary();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            valid = 2'b01;
            data  = {8'h00, 8'(8'h10 + i)};
            tick();
        end
        data  = 16'h0099;
        rd_en = 1'b1;
        #1;
        n_tests++; if (ready !== 2'b00) begin n_fail++; $display("FAIL bnd_ready_full: got %b want 00", ready); end
        tick();
        n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL bnd_rd_valid: got %b want 1", rd_valid); end
        n_tests++; if (rd_data !== 8'h10) begin n_fail++; $display("FAIL bnd_rd_data: got %h want 10", rd_data); end
        n_tests++; if (count !== 5'd15) begin n_fail++; $display("FAIL bnd_count: got %0d want 15", count); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL bnd_full: got %b want 0", full); end
        rd_en = 1'b0;
        #1;
        n_tests++; if (ready !== 2'b01) begin n_fail++; $display("FAIL bnd_ready_reenable: got %b want 01", ready); end
        tick();
        n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL bnd_count_refill: got %0d want 16", count); end
        valid = 2'b00;
        for (int k = 0; k < 16; k++) begin
            exp   = (k < 15) ? 8'(8'h11 + k) : 8'h99;
            rd_en = 1'b1;
            tick();
            n_tests++; if (rd_data !== exp) begin n_fail++; $display("FAIL bnd_drain pop %0d: got %h want %h", k, rd_data, exp); end
        end
        tick();
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL bnd_pop_empty_valid: got %b want 0", rd_valid); end
        n_tests++; if (rd_data !== 8'h99) begin n_fail++; $display("FAIL bnd_pop_empty_hold: got %h want 99", rd_data); end
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL bnd_pop_empty_count: got %0d want 0", count); end
        rd_en = 1'b0;
    endtask

    task automatic test_arbitration();
        logic [7:0] n0;
        logic [7:0] n1;
        logic [1:0] exp_rdy;
        logic [7:0] exp_d;
        do_reset();
        n0 = 8'd0;
        n1 = 8'd0;
        for (int i = 0; i < 4; i++) begin
            valid   = 2'b11;
            data    = {8'hB0 + n1, 8'hA0 + n0};
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            n_tests++; if (ready !== exp_rdy) begin n_fail++; $display("FAIL arb_grant %0d: got %b want %b", i, ready, exp_rdy); end
            tick();
            if (i % 2 == 0) n0 = n0 + 8'd1;
            else            n1 = n1 + 8'd1;
        end
        valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0) ? 8'(8'hA0 + k/2) : 8'(8'hB0 + k/2);
            rd_en = 1'b1;
            tick();
            n_tests++; if (rd_chan !== 1'(k % 2)) begin n_fail++; $display("FAIL arb_rd_chan %0d: got %0d want %0d", k, rd_chan, k % 2); end
            n_tests++; if (rd_data !== exp_d) begin n_fail++; $display("FAIL arb_rd_data %0d: got %h want %h", k, rd_data, exp_d); end
        end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 18; i++) begin
            w_valid = 2'b01;
            w_data  = {8'h00, 8'(i)};
            #1;
            n_tests++; if (w_ready !== 2'b01) begin n_fail++; $display("FAIL wrap_ready wr %0d: got %b want 01", i, w_ready); end
            tick();
        end
        w_valid = 2'b00;
        #1;
        n_tests++; if (w_count !== 5'd16) begin n_fail++; $display("FAIL wrap_count: got %0d want 16", w_count); end
        n_tests++; if (w_full !== 1'b1) begin n_fail++; $display("FAIL wrap_full: got %b want 1", w_full); end
`ifdef STREAM_CAPTURE_OVF_CNT_EN
        n_tests++; if (w_ovf_cnt !== 16'd2) begin n_fail++; $display("FAIL wrap_ovf_cnt: got %0d want 2", w_ovf_cnt); end
`endif
        for (int k = 3; k <= 18; k++) begin
            w_rd_en = 1'b1;
            tick();
            n_tests++; if (w_rd_data !== 8'(k)) begin n_fail++; $display("FAIL wrap_pop: got %h want %h", w_rd_data, 8'(k)); end
        end
        w_rd_en = 1'b0;
        tick();
        n_tests++; if (w_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", w_empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 5; i++) begin
            valid = 2'b01;
            data  = {8'h00, 8'(i)};
            tick();
        end
        n_tests++; if (count !== 5'd5) begin n_fail++; $display("FAIL mid_count_pre: got %0d want 5", count); end
        rst   = 1'b0;
        rd_en = 1'b1;
        #1;
        n_tests++; if (ready !== 2'b00) begin n_fail++; $display("FAIL mid_ready_in_reset: got %b want 00", ready); end
        tick();
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", count); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b want 1", empty); end
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rd_valid: got %b want 0", rd_valid); end
        rst   = 1'b1;
        rd_en = 1'b0;
        data  = 16'h0055;
        #1;
        n_tests++; if (ready !== 2'b01) begin n_fail++; $display("FAIL mid_ready_after: got %b want 01", ready); end
        tick();
        n_tests++; if (count !== 5'd1) begin n_fail++; $display("FAIL mid_count_one: got %0d want 1", count); end
        data  = 16'h0066;
        rd_en = 1'b1;
        tick();
        n_tests++; if (rd_data !== 8'h55) begin n_fail++; $display("FAIL mid_pop55: got %h want 55", rd_data); end
        n_tests++; if (count !== 5'd1) begin n_fail++; $display("FAIL mid_count_wr_pop: got %0d want 1", count); end
        valid = 2'b00;
        tick();
        n_tests++; if (rd_data !== 8'h66) begin n_fail++; $display("FAIL mid_pop66: got %h want 66", rd_data); end
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL mid_count_end: got %0d want 0", count); end
        rd_en = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        valid   = 2'b00;
        data    = '0;
        rd_en   = 1'b0;
        w_valid = 2'b00;
        w_data  = '0;
        w_rd_en = 1'b0;
        test_reset();
        test_single();
        test_full_boundary();
        test_arbitration();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
